vga_framebuffer_arbiter: RTL and testbench

//  Shares one single-port framebuffer memory (Avalon, variable read latency) between the pixel

---
 rtl/vga_arb_pkg.sv | 20 ++
 rtl/vga_arb_tag_fifo.sv | 59 +++++
 rtl/vga_framebuffer_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_vga_framebuffer_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared types and helpers for the framebuffer arbiter
package vga_arb_pkg;

   typedef enum logic {
      OWN_PXL = 1'b0,
      OWN_PRO = 1'b1
   } owner_t;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK_PXL = 2'd1,
      LOCK_PRO = 2'd2
   } lock_state_t;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int tag_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vga_arb_tag_fifo.sv
// rtl/vga_arb_tag_fifo.sv - owner tag FIFO for reads in flight at the memory
// Push is ignored when full and pop when empty; full/empty come from the registered count.
module vga_arb_tag_fifo
   import vga_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  owner_t din_i,
   input  logic   pop_i,
   output logic   full_o,
   output logic   empty_o,
   output owner_t dout_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = tag_cnt_w(DEPTH);

   owner_t          slot_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = slot_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) slot_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/vga_framebuffer_arbiter.sv
// rtl/vga_framebuffer_arbiter.sv - single-port framebuffer arbiter, pxl priority with pro starvation guard
// Optional statistics counters are enabled by defining VGA_ARB_STATS_EN.
module vga_framebuffer_arbiter
   import vga_arb_pkg::*;
#(
   parameter int AVN_AW          = 18,
   parameter int AVN_DW          = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int PXL_MAX_STREAK  = 8
`ifdef VGA_ARB_STATS_EN
   ,
   parameter int STAT_W          = 32
`endif
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                pro_avn_read,
   input  logic                pro_avn_write,
   input  logic [AVN_AW-1:0]   pro_avn_address,
   input  logic [AVN_DW-1:0]   pro_avn_writedata,
   input  logic [AVN_DW/8-1:0] pro_avn_byteenable,
   output logic [AVN_DW-1:0]   pro_avn_readdata,
   output logic                pro_avn_readdatavalid,
   output logic                pro_avn_waitrequest,
   input  logic                pxl_avn_read,
   input  logic                pxl_avn_write,
   input  logic [AVN_AW-1:0]   pxl_avn_address,
   input  logic [AVN_DW-1:0]   pxl_avn_writedata,
   input  logic [AVN_DW/8-1:0] pxl_avn_byteenable,
   output logic [AVN_DW-1:0]   pxl_avn_readdata,
   output logic                pxl_avn_readdatavalid,
   output logic                pxl_avn_waitrequest,
   output logic                mem_avn_read,
   output logic                mem_avn_write,
   output logic [AVN_AW-1:0]   mem_avn_address,
   output logic [AVN_DW-1:0]   mem_avn_writedata,
   output logic [AVN_DW/8-1:0] mem_avn_byteenable,
   input  logic [AVN_DW-1:0]   mem_avn_readdata,
   input  logic                mem_avn_readdatavalid,
   input  logic                mem_avn_waitrequest,
   output logic                arb_err
`ifdef VGA_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]   stat_pxl_grant,
   output logic [STAT_W-1:0]   stat_pro_grant,
   output logic [STAT_W-1:0]   stat_pro_stall
`endif
);

   localparam int SW = $clog2(PXL_MAX_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(PXL_MAX_STREAK);

   lock_state_t state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          err_q, err_d;
   logic          active_q;

   logic   pxl_req, pro_req;
   logic   sel_vld;
   owner_t sel_own;
   logic   s_read, s_write, s_rd, s_wr;
   logic   mem_cmd, accept, sel_wait;
   logic   tag_full, tag_empty;
   owner_t tag_dout;
   logic   rdv_ok;

   assign pxl_req = pxl_avn_read | pxl_avn_write;
   assign pro_req = pro_avn_read | pro_avn_write;

   // Unlocked selection is combinational so an idle memory sees a zero-cycle pass-through.
   always_comb begin
      sel_vld = 1'b0;
      sel_own = OWN_PXL;
      unique case (state_q)
         UNLOCKED: begin
            if (pro_req && (!pxl_req || streak_q == STREAK_MAX)) begin
               sel_vld = 1'b1;
               sel_own = OWN_PRO;
            end else if (pxl_req) begin
               sel_vld = 1'b1;
               sel_own = OWN_PXL;
            end
         end
         LOCK_PXL: begin
            sel_vld = pxl_req;
            sel_own = OWN_PXL;
         end
         LOCK_PRO: begin
            sel_vld = pro_req;
            sel_own = OWN_PRO;
         end
         default: ;
      endcase
      if (!active_q) sel_vld = 1'b0;
   end

   assign s_read             = (sel_own == OWN_PRO) ? pro_avn_read       : pxl_avn_read;
   assign s_write            = (sel_own == OWN_PRO) ? pro_avn_write      : pxl_avn_write;
   assign mem_avn_address    = (sel_own == OWN_PRO) ? pro_avn_address    : pxl_avn_address;
   assign mem_avn_writedata  = (sel_own == OWN_PRO) ? pro_avn_writedata  : pxl_avn_writedata;
   assign mem_avn_byteenable = (sel_own == OWN_PRO) ? pro_avn_byteenable : pxl_avn_byteenable;

   // An illegal read+write pair is issued as the write.
   assign s_wr          = sel_vld & s_write;
   assign s_rd          = sel_vld & s_read & ~s_write;
   assign mem_avn_write = s_wr;
   assign mem_avn_read  = s_rd & ~tag_full;
   assign mem_cmd       = mem_avn_read | mem_avn_write;
   assign accept        = mem_cmd & ~mem_avn_waitrequest;
   assign sel_wait      = mem_avn_waitrequest | (s_rd & tag_full);

   assign pxl_avn_waitrequest = ~(sel_vld && sel_own == OWN_PXL) | sel_wait;
   assign pro_avn_waitrequest = ~(sel_vld && sel_own == OWN_PRO) | sel_wait;

   always_comb begin
      state_d = state_q;
      if (sel_vld && mem_cmd && mem_avn_waitrequest)
         state_d = (sel_own == OWN_PRO) ? LOCK_PRO : LOCK_PXL;
      else if (state_q != UNLOCKED && (accept || !sel_vld))
         state_d = UNLOCKED;
   end

   always_comb begin
      streak_d = streak_q;
      if (!pxl_req || (accept && sel_own == OWN_PRO))
         streak_d = '0;
      else if (accept && sel_own == OWN_PXL && streak_q != STREAK_MAX)
         streak_d = streak_q + SW'(1);
   end

   vga_arb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk_i   (sys_clk),
      .rst_ni  (sys_rst_n),
      .push_i  (accept & mem_avn_read),
      .din_i   (sel_own),
      .pop_i   (mem_avn_readdatavalid),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .dout_o  (tag_dout)
   );

   assign rdv_ok                = active_q & mem_avn_readdatavalid & ~tag_empty;
   assign pxl_avn_readdatavalid = rdv_ok & (tag_dout == OWN_PXL);
   assign pro_avn_readdatavalid = rdv_ok & (tag_dout == OWN_PRO);
   assign pxl_avn_readdata      = mem_avn_readdata;
   assign pro_avn_readdata      = mem_avn_readdata;

   always_comb begin
      err_d = err_q;
      if (mem_avn_readdatavalid && tag_empty) err_d = 1'b1;
      if (active_q && ((pxl_avn_read && pxl_avn_write) || (pro_avn_read && pro_avn_write)))
         err_d = 1'b1;
   end
   assign arb_err = err_q;

   // active_q holds every master-facing output at its reset value until the first edge after reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= UNLOCKED;
         streak_q <= '0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         err_q    <= err_d;
         active_q <= 1'b1;
      end
   end

`ifdef VGA_ARB_STATS_EN
   logic [STAT_W-1:0] st_pxl_q, st_pxl_d;
   logic [STAT_W-1:0] st_pro_q, st_pro_d;
   logic [STAT_W-1:0] st_stall_q, st_stall_d;

   always_comb begin
      st_pxl_d   = st_pxl_q;
      st_pro_d   = st_pro_q;
      st_stall_d = st_stall_q;
      if (accept && sel_own == OWN_PXL && !(&st_pxl_q)) st_pxl_d = st_pxl_q + STAT_W'(1);
      if (accept && sel_own == OWN_PRO && !(&st_pro_q)) st_pro_d = st_pro_q + STAT_W'(1);
      if (pro_req && pro_avn_waitrequest && !(&st_stall_q)) st_stall_d = st_stall_q + STAT_W'(1);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         st_pxl_q   <= '0;
         st_pro_q   <= '0;
         st_stall_q <= '0;
      end else begin
         st_pxl_q   <= st_pxl_d;
         st_pro_q   <= st_pro_d;
         st_stall_q <= st_stall_d;
      end
   end

   assign stat_pxl_grant = st_pxl_q;
   assign stat_pro_grant = st_pro_q;
   assign stat_pro_stall = st_stall_q;
`endif

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// tb/tb_vga_framebuffer_arbiter.sv - self-checking bench for vga_framebuffer_arbiter
module tb_vga_framebuffer_arbiter;

   typedef struct {
      logic        own;
      logic [15:0] data;
   } exp_t;

   typedef struct {
      logic [17:0] addr;
      int          due;
   } mrsp_t;

   logic        sys_clk, sys_rst_n;
   logic        pro_avn_read, pro_avn_write;
   logic [17:0] pro_avn_address;
   logic [15:0] pro_avn_writedata;
   logic [1:0]  pro_avn_byteenable;
   logic [15:0] pro_avn_readdata;
   logic        pro_avn_readdatavalid, pro_avn_waitrequest;
   logic        pxl_avn_read, pxl_avn_write;
   logic [17:0] pxl_avn_address;
   logic [15:0] pxl_avn_writedata;
   logic [1:0]  pxl_avn_byteenable;
   logic [15:0] pxl_avn_readdata;
   logic        pxl_avn_readdatavalid, pxl_avn_waitrequest;
   logic        mem_avn_read, mem_avn_write;
   logic [17:0] mem_avn_address;
   logic [15:0] mem_avn_writedata;
   logic [1:0]  mem_avn_byteenable;
   logic [15:0] mem_avn_readdata;
   logic        mem_avn_readdatavalid, mem_avn_waitrequest;
   logic        arb_err;
`ifdef VGA_ARB_STATS_EN
   logic [31:0] stat_pxl_grant, stat_pro_grant, stat_pro_stall;
`endif

   exp_t  exp_q[$];
   mrsp_t mq[$];
   int    vec = 0;
   int    mis = 0;
   int    cyc = 0;
   int    lat = 3;
   logic  spur = 1'b0;

   vga_framebuffer_arbiter dut (
      .sys_clk               (sys_clk),
      .sys_rst_n             (sys_rst_n),
      .pro_avn_read          (pro_avn_read),
      .pro_avn_write         (pro_avn_write),
      .pro_avn_address       (pro_avn_address),
      .pro_avn_writedata     (pro_avn_writedata),
      .pro_avn_byteenable    (pro_avn_byteenable),
      .pro_avn_readdata      (pro_avn_readdata),
      .pro_avn_readdatavalid (pro_avn_readdatavalid),
      .pro_avn_waitrequest   (pro_avn_waitrequest),
      .pxl_avn_read          (pxl_avn_read),
      .pxl_avn_write         (pxl_avn_write),
      .pxl_avn_address       (pxl_avn_address),
      .pxl_avn_writedata     (pxl_avn_writedata),
      .pxl_avn_byteenable    (pxl_avn_byteenable),
      .pxl_avn_readdata      (pxl_avn_readdata),
      .pxl_avn_readdatavalid (pxl_avn_readdatavalid),
      .pxl_avn_waitrequest   (pxl_avn_waitrequest),
      .mem_avn_read          (mem_avn_read),
      .mem_avn_write         (mem_avn_write),
      .mem_avn_address       (mem_avn_address),
      .mem_avn_writedata     (mem_avn_writedata),
      .mem_avn_byteenable    (mem_avn_byteenable),
      .mem_avn_readdata      (mem_avn_readdata),
      .mem_avn_readdatavalid (mem_avn_readdatavalid),
      .mem_avn_waitrequest   (mem_avn_waitrequest),
      .arb_err               (arb_err)
`ifdef VGA_ARB_STATS_EN
      ,
      .stat_pxl_grant        (stat_pxl_grant),
      .stat_pro_grant        (stat_pro_grant),
      .stat_pro_stall        (stat_pro_stall)
`endif
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] dfun(input logic [17:0] a);
      return a[15:0] ^ 16'h5A3C;
   endfunction

   task automatic half();
      @(negedge sys_clk);
   endtask

   // Scoreboard and memory model: runs from mid-cycle to just after the next rising edge.
   task automatic fin();
      logic        pxl_acc, pro_acc, mrd;
      logic [17:0] ma;
      exp_t        e;
      mrsp_t       m;
      pxl_acc = (pxl_avn_read | pxl_avn_write) & ~pxl_avn_waitrequest;
      pro_acc = (pro_avn_read | pro_avn_write) & ~pro_avn_waitrequest;
      mrd     = mem_avn_read & ~mem_avn_waitrequest;
      ma      = mem_avn_address;
      if (pxl_avn_readdatavalid || pro_avn_readdatavalid) begin
         vec++;
         if (exp_q.size() == 0) begin
            mis++;
            $display("FAIL rdv_unexpected: pxl_rdv=%b pro_rdv=%b, required none", pxl_avn_readdatavalid, pro_avn_readdatavalid);
         end else begin
            e = exp_q.pop_front();
            if ({pro_avn_readdatavalid, pxl_avn_readdatavalid} !== (e.own ? 2'b10 : 2'b01) ||
                (e.own ? pro_avn_readdata : pxl_avn_readdata) !== e.data) begin
               mis++;
               $display("FAIL rdv_route: pro/pxl rdv=%b%b data=%h, required owner=%b data=%h",
                        pro_avn_readdatavalid, pxl_avn_readdatavalid,
                        (e.own ? pro_avn_readdata : pxl_avn_readdata), e.own, e.data);
            end
         end
      end
      if (pxl_acc && pxl_avn_read && !pxl_avn_write) exp_q.push_back('{1'b0, dfun(pxl_avn_address)});
      if (pro_acc && pro_avn_read && !pro_avn_write) exp_q.push_back('{1'b1, dfun(pro_avn_address)});
      @(posedge sys_clk);
      cyc++;
      #1;
      if (mrd) mq.push_back('{ma, cyc - 1 + lat});
      mem_avn_readdatavalid = 1'b0;
      if (spur) begin
         mem_avn_readdatavalid = 1'b1;
         mem_avn_readdata      = 16'hDEAD;
         spur                  = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
         m = mq.pop_front();
         mem_avn_readdatavalid = 1'b1;
         mem_avn_readdata      = dfun(m.addr);
      end
   endtask

   task automatic drain();
      int n = 0;
      pxl_avn_read = 0; pxl_avn_write = 0; pro_avn_read = 0; pro_avn_write = 0;
      while ((exp_q.size() > 0 || mq.size() > 0 || mem_avn_readdatavalid) && n < 60) begin
         half();
         fin();
         n++;
      end
      vec++;
      if (exp_q.size() != 0) begin
         mis++;
         $display("FAIL drain: %0d responses still owed, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      pro_avn_write = 1'b1; pro_avn_address = 18'h20010; pro_avn_writedata = 16'h1234;
      repeat (2) @(posedge sys_clk);
      half();
      vec++;
      if ({mem_avn_read, mem_avn_write, pxl_avn_waitrequest, pro_avn_waitrequest,
           pxl_avn_readdatavalid, pro_avn_readdatavalid, arb_err} !== 7'b0011000) begin
         mis++;
         $display("FAIL reset_vals: got %b, required 0011000", {mem_avn_read, mem_avn_write,
                  pxl_avn_waitrequest, pro_avn_waitrequest, pxl_avn_readdatavalid, pro_avn_readdatavalid, arb_err});
      end
      sys_rst_n = 1'b1;
      #1;
      vec++;
      if ({mem_avn_write, pro_avn_waitrequest} !== 2'b01) begin
         mis++;
         $display("FAIL reset_release_hold: write/wait=%b, required 01", {mem_avn_write, pro_avn_waitrequest});
      end
      fin();
      half();
      vec++;
      if ({mem_avn_write, pro_avn_waitrequest} !== 2'b10 || mem_avn_address !== 18'h20010 ||
          mem_avn_writedata !== 16'h1234) begin
         mis++;
         $display("FAIL first_write: write/wait=%b addr=%h data=%h, required 10 20010 1234",
                  {mem_avn_write, pro_avn_waitrequest}, mem_avn_address, mem_avn_writedata);
      end
      fin();
      pro_avn_write = 1'b0;
   endtask

   task automatic test_priority();
      logic [17:0] pa = 18'h00100;
      logic [17:0] ra = 18'h20000;
      logic        want_pro;
      lat = 3;
      mem_avn_waitrequest = 1'b0;
      pxl_avn_read = 1'b1;
      pro_avn_read = 1'b1;
      for (int i = 0; i < 36; i++) begin
         pxl_avn_address = pa;
         pro_avn_address = ra;
         half();
         want_pro = (i % 9 == 8);
         vec++;
         if ({~pro_avn_waitrequest, ~pxl_avn_waitrequest} !== (want_pro ? 2'b10 : 2'b01) ||
             mem_avn_address !== (want_pro ? ra : pa)) begin
            mis++;
            $display("FAIL priority[%0d]: pro/pxl grant=%b addr=%h, required %b addr=%h", i,
                     {~pro_avn_waitrequest, ~pxl_avn_waitrequest}, mem_avn_address,
                     (want_pro ? 2'b10 : 2'b01), (want_pro ? ra : pa));
         end
         if (!pxl_avn_waitrequest) pa = pa + 18'd1;
         if (!pro_avn_waitrequest) ra = ra + 18'd1;
         fin();
      end
      drain();
   endtask

   task automatic test_lock();
      lat = 3;
      mem_avn_waitrequest = 1'b1;
      pxl_avn_read = 1'b1;
      pxl_avn_address = 18'h00345;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            pro_avn_write = 1'b1; pro_avn_address = 18'h20777; pro_avn_writedata = 16'hBEEF;
         end
         if (i == 4) mem_avn_waitrequest = 1'b0;
         half();
         vec++;
         if ({mem_avn_read, mem_avn_write} !== 2'b10 || mem_avn_address !== 18'h00345 ||
             (i >= 2 && pro_avn_waitrequest !== 1'b1) || pxl_avn_waitrequest !== (i < 4)) begin
            mis++;
            $display("FAIL lock[%0d]: rd/wr=%b addr=%h pro_wait=%b pxl_wait=%b, required 10 00345 1 %b", i,
                     {mem_avn_read, mem_avn_write}, mem_avn_address, pro_avn_waitrequest,
                     pxl_avn_waitrequest, (i < 4));
         end
         fin();
      end
      pxl_avn_read = 1'b0;
      half();
      vec++;
      if ({mem_avn_read, mem_avn_write, pro_avn_waitrequest} !== 3'b010 ||
          mem_avn_address !== 18'h20777 || mem_avn_writedata !== 16'hBEEF) begin
         mis++;
         $display("FAIL lock_release: rd/wr/pro_wait=%b addr=%h data=%h, required 010 20777 beef",
                  {mem_avn_read, mem_avn_write, pro_avn_waitrequest}, mem_avn_address, mem_avn_writedata);
      end
      fin();
      drain();
   endtask

   task automatic test_outstanding();
      logic [17:0] pa = 18'h01000;
      int          tb_cnt = 0;
      logic        can, pop;
      lat = 10;
      mem_avn_waitrequest = 1'b0;
      pxl_avn_read = 1'b1;
      for (int i = 0; i < 28; i++) begin
         pxl_avn_address = pa;
         half();
         can = (tb_cnt < 4);
         pop = mem_avn_readdatavalid;
         vec++;
         if (pxl_avn_waitrequest !== !can || mem_avn_read !== can) begin
            mis++;
            $display("FAIL outstanding[%0d]: pxl_wait=%b mem_read=%b, required %b %b (in flight %0d, pop %b)",
                     i, pxl_avn_waitrequest, mem_avn_read, !can, can, tb_cnt, pop);
         end
         fin();
         tb_cnt = tb_cnt + int'(can) - int'(pop);
         if (can) pa = pa + 18'd1;
      end
      drain();
   endtask

   task automatic test_spurious();
      half();
      vec++;
      if (arb_err !== 1'b0) begin
         mis++;
         $display("FAIL err_clean: arb_err=%b, required 0", arb_err);
      end
      spur = 1'b1;
      fin();
      half();
      vec++;
      if ({pxl_avn_readdatavalid, pro_avn_readdatavalid} !== 2'b00) begin
         mis++;
         $display("FAIL spurious_rdv: pxl/pro rdv=%b, required 00", {pxl_avn_readdatavalid, pro_avn_readdatavalid});
      end
      fin();
      half();
      vec++;
      if (arb_err !== 1'b1) begin
         mis++;
         $display("FAIL spurious_err: arb_err=%b, required 1", arb_err);
      end
      repeat (3) begin
         fin();
         half();
      end
      vec++;
      if (arb_err !== 1'b1) begin
         mis++;
         $display("FAIL err_sticky: arb_err=%b, required 1", arb_err);
      end
      fin();
   endtask

   task automatic test_reset_mid();
      logic [17:0] pa = 18'h02000;
      lat = 10;
      mem_avn_waitrequest = 1'b0;
      pxl_avn_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pxl_avn_address = pa;
         half();
         vec++;
         if (pxl_avn_waitrequest !== 1'b0) begin
            mis++;
            $display("FAIL rst_mid_issue[%0d]: pxl_wait=%b, required 0", i, pxl_avn_waitrequest);
         end
         fin();
         pa = pa + 18'd1;
      end
      pxl_avn_read = 1'b0;
      half();
      fin();
      half();
      sys_rst_n = 1'b0;
      #1;
      exp_q.delete();
      vec++;
      if ({mem_avn_read, mem_avn_write, pxl_avn_waitrequest, pro_avn_waitrequest,
           pxl_avn_readdatavalid, pro_avn_readdatavalid, arb_err} !== 7'b0011000) begin
         mis++;
         $display("FAIL rst_mid_vals: got %b, required 0011000", {mem_avn_read, mem_avn_write,
                  pxl_avn_waitrequest, pro_avn_waitrequest, pxl_avn_readdatavalid, pro_avn_readdatavalid, arb_err});
      end
`ifdef VGA_ARB_STATS_EN
      vec++;
      if (stat_pxl_grant !== 32'd0 || stat_pro_grant !== 32'd0 || stat_pro_stall !== 32'd0) begin
         mis++;
         $display("FAIL stats_reset: %0d %0d %0d, required 0 0 0", stat_pxl_grant, stat_pro_grant, stat_pro_stall);
      end
`endif
      fin();
      half();
      fin();
      sys_rst_n = 1'b1;
      half();
      vec++;
      if (arb_err !== 1'b0) begin
         mis++;
         $display("FAIL rst_mid_err_early: arb_err=%b, required 0", arb_err);
      end
      fin();
      drain();
      half();
      vec++;
      if (arb_err !== 1'b1) begin
         mis++;
         $display("FAIL rst_mid_late_resp: arb_err=%b, required 1", arb_err);
      end
      fin();
   endtask

   initial begin
      sys_rst_n = 1'b0;
      pro_avn_read = 0; pro_avn_write = 0; pro_avn_address = '0;
      pro_avn_writedata = '0; pro_avn_byteenable = 2'b11;
      pxl_avn_read = 0; pxl_avn_write = 0; pxl_avn_address = '0;
      pxl_avn_writedata = '0; pxl_avn_byteenable = 2'b11;
      mem_avn_readdata = '0; mem_avn_readdatavalid = 0; mem_avn_waitrequest = 0;
      test_reset();
      test_priority();
      test_lock();
      test_outstanding();
      test_spurious();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
